// File: rtl/cache_arb_pkg.sv
// Shared types and defaults for the cache/memory arbiter.
// Round-robin tie-break is selected by ARB_ROUND_ROBIN_EN in the top module.
package cache_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int CTR_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_wait_ctr.sv
// Wait-state down-counter: loads on grant, decrements while the access runs.
// The zero flag marks the last wait cycle of the access.
module arb_wait_ctr
  import cache_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CTR_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between the I-cache (m0) and D-cache (m1).
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise m1 always wins ties.
//
// state  | meaning
// IDLE   | no access; arbitrate strobes at the next edge
// ACCESS | memory bus driven from the owner for WAIT_CYCLES cycles
// DONE   | one-cycle ready pulse to the owner, read data valid
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_strobe,
  input  logic              m0_rw,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_strobe,
  input  logic              m1_rw,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_strobe,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(WAIT_CYCLES - 1);

  arb_state_t        state;
  owner_t            owner;
  owner_t            winner;
  logic [DATA_W-1:0] rdata_q;
  logic              req_any;
  logic              ctr_load;
  logic              ctr_dec;
  logic              ctr_zero;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t            last_owner;
`endif

  assign req_any  = m0_strobe | m1_strobe;
  assign ctr_load = (state == IDLE) && req_any;
  assign ctr_dec  = (state == ACCESS);

  arb_wait_ctr u_wait_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (CTR_INIT),
    .dec      (ctr_dec),
    .zero     (ctr_zero)
  );

  always_comb begin
    winner = OWN_D;
    if (m0_strobe && m1_strobe) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = (last_owner == OWN_D) ? OWN_I : OWN_D;
`else
      winner = OWN_D;
`endif
    end else if (m0_strobe) begin
      winner = OWN_I;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      owner   <= OWN_I;
      rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner <= OWN_D;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            owner <= winner;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= winner;
`endif
            state <= ACCESS;
          end
        end
        ACCESS: begin
          // the owner's strobe is not consulted here: a dropped strobe still completes
          if (ctr_zero) begin
            if (mem_rw) rdata_q <= mem_rdata;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_strobe = (state == ACCESS);
    mem_rw     = 1'b1;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (mem_strobe) begin
      if (owner == OWN_I) begin
        mem_rw    = m0_rw;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
      end else begin
        mem_rw    = m1_rw;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
      end
    end
  end

  assign m0_ready = (state == DONE) && (owner == OWN_I);
  assign m1_ready = (state == DONE) && (owner == OWN_D);
  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench: two arbiters (WAIT_CYCLES 4 and 1) on shared stimulus,
// checked every cycle against a transaction-timeline model plus directed literals.
module tb_cache_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int WC0 = 4;
  localparam int WC1 = 1;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          s0, s1, rw0, rw1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] wd0, wd1, mrd;

  logic          ms [2];
  logic          mrw [2];
  logic          rdy0 [2];
  logic          rdy1 [2];
  logic [AW-1:0] ma [2];
  logic [DW-1:0] mwd [2];
  logic [DW-1:0] rd0 [2];
  logic [DW-1:0] rd1 [2];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC0)) dut0 (
    .clk(clk), .rst(rst),
    .m0_strobe(s0), .m0_rw(rw0), .m0_addr(a0), .m0_wdata(wd0),
    .m0_ready(rdy0[0]), .m0_rdata(rd0[0]),
    .m1_strobe(s1), .m1_rw(rw1), .m1_addr(a1), .m1_wdata(wd1),
    .m1_ready(rdy1[0]), .m1_rdata(rd1[0]),
    .mem_strobe(ms[0]), .mem_rw(mrw[0]), .mem_addr(ma[0]), .mem_wdata(mwd[0]),
    .mem_rdata(mrd)
  );

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC1)) dut1 (
    .clk(clk), .rst(rst),
    .m0_strobe(s0), .m0_rw(rw0), .m0_addr(a0), .m0_wdata(wd0),
    .m0_ready(rdy0[1]), .m0_rdata(rd0[1]),
    .m1_strobe(s1), .m1_rw(rw1), .m1_addr(a1), .m1_wdata(wd1),
    .m1_ready(rdy1[1]), .m1_rdata(rd1[1]),
    .mem_strobe(ms[1]), .mem_rw(mrw[1]), .mem_addr(ma[1]), .mem_wdata(mwd[1]),
    .mem_rdata(mrd)
  );

  task automatic check(input string nm, input int idx,
                       input longint unsigned got, input longint unsigned want);
    total_cnt++;
    if (got == want) pass_cnt++;
    else $display("FAIL %s[%0d] got 0x%0h want 0x%0h at %0t", nm, idx, got, want, $time);
  endtask

  // Timeline model: a grant at edge g puts the bus up for edges g..g+W-1,
  // ready follows after edge g+W, the next grant can come at edge g+W+2.
  int            wc [2] = '{WC0, WC1};
  bit            act [2] = '{1'b0, 1'b0};
  longint        g [2] = '{0, 0};
  int            own [2] = '{0, 0};
  int            last [2] = '{1, 1};
  logic [DW-1:0] rexp [2] = '{'0, '0};
  longint        e = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e = 0;
      for (int k = 0; k < 2; k++) begin
        act[k] = 1'b0; g[k] = 0; own[k] = 0; last[k] = 1; rexp[k] = '0;
      end
    end else begin
      e = e + 1;
      for (int k = 0; k < 2; k++) begin
        if (act[k] && (e == g[k] + wc[k]) && ((own[k] == 0) ? rw0 : rw1))
          rexp[k] = mrd;
        if ((!act[k] || (e >= g[k] + wc[k] + 2)) && (s0 || s1)) begin
          if (s0 && s1) own[k] = RR ? (1 - last[k]) : 1;
          else          own[k] = s0 ? 0 : 1;
          last[k] = own[k];
          act[k]  = 1'b1;
          g[k]    = e;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      longint d;
      bit es, er;
      d  = e - g[k];
      es = act[k] && (d < wc[k]);
      er = act[k] && (d == wc[k]);
      check("mem_strobe", k, ms[k], es);
      check("mem_rw", k, mrw[k], es ? ((own[k] == 0) ? rw0 : rw1) : 1'b1);
      check("mem_addr", k, ma[k], es ? ((own[k] == 0) ? a0 : a1) : '0);
      check("mem_wdata", k, mwd[k], es ? ((own[k] == 0) ? wd0 : wd1) : '0);
      check("m0_ready", k, rdy0[k], er && (own[k] == 0));
      check("m1_ready", k, rdy1[k], er && (own[k] == 1));
      if (er) begin
        check("m0_rdata", k, rd0[k], rexp[k]);
        check("m1_rdata", k, rd1[k], rexp[k]);
      end
    end
  end

  // Directed-test observation on both instances
  int first_rdy [2][2];
  int nrdy [2][2];
  int scount [2];
  int bus_bad;
  int log_own [$];
  int log_cyc [$];
  logic          w_rw;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 2; i++) begin
      scount[i] = 0;
      for (int r = 0; r < 2; r++) begin first_rdy[i][r] = -1; nrdy[i][r] = 0; end
    end
    bus_bad = 0;
    log_own.delete();
    log_cyc.delete();
  endtask

  // Cycle 0 is the one before the sampling edge; strobes drop after own ready unless held.
  task automatic observe(input int n, input bit hold);
    for (int k = 0; k < n; k++) begin
      bit seen0, seen1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (ms[i] && first_rdy[i][0] < 0 && first_rdy[i][1] < 0) scount[i]++;
        for (int r = 0; r < 2; r++) begin
          if ((r == 0) ? rdy0[i] : rdy1[i]) begin
            nrdy[i][r]++;
            if (first_rdy[i][r] < 0) first_rdy[i][r] = k;
          end
        end
      end
      if (ms[0] && (mrw[0] !== w_rw || ma[0] !== w_addr || mwd[0] !== w_wdata)) bus_bad++;
      if (rdy0[0]) begin log_own.push_back(0); log_cyc.push_back(k); end
      if (rdy1[0]) begin log_own.push_back(1); log_cyc.push_back(k); end
      seen0 = rdy0[0];
      seen1 = rdy1[0];
      tick();
      if (!hold) begin
        if (seen0) s0 = 1'b0;
        if (seen1) s1 = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    int exp_seq [4];
    rst = 1'b0;
    s0 = 0; s1 = 0; rw0 = 1; rw1 = 1;
    a0 = '0; a1 = '0; wd0 = '0; wd1 = '0; mrd = '0;
    w_rw = 1; w_addr = '0; w_wdata = '0;
    repeat (2) tick();
    check("rst_mem_strobe", 0, ms[0], 0);
    check("rst_mem_rw", 0, mrw[0], 1);
    check("rst_mem_addr", 0, ma[0], 0);
    check("rst_ready", 0, {rdy0[0], rdy1[0]}, 0);
    check("rst_rdata", 0, rd0[0], 0);
    rst = 1'b1;
    tick();

    // m0 read: 4 strobe cycles, ready in cycle 5 (1 and 2 for the WAIT_CYCLES=1 copy)
    clear_obs();
    a0 = 32'h100; rw0 = 1; mrd = 32'hDEADBEEF; s0 = 1;
    w_rw = 1; w_addr = 32'h100; w_wdata = '0;
    observe(12, 1'b0);
    check("rd_strobe_cycles", 0, scount[0], 4);
    check("rd_ready_cycle", 0, first_rdy[0][0], 5);
    check("rd_ready_count", 0, nrdy[0][0], 1);
    check("rd_no_m1_ready", 0, nrdy[0][1], 0);
    check("rd_bus", 0, bus_bad, 0);
    check("rd_strobe_cycles", 1, scount[1], 1);
    check("rd_ready_cycle", 1, first_rdy[1][0], 2);
    check("rd_data", 0, rd0[0], 32'hDEADBEEF);
    repeat (4) tick();

    // m1 write
    clear_obs();
    a1 = 32'h200; wd1 = 32'h12345678; rw1 = 0; mrd = 32'hA5A5A5A5; s1 = 1;
    w_rw = 0; w_addr = 32'h200; w_wdata = 32'h12345678;
    observe(12, 1'b0);
    check("wr_bus", 0, bus_bad, 0);
    check("wr_strobe_cycles", 0, scount[0], 4);
    check("wr_m1_ready_count", 0, nrdy[0][1], 1);
    check("wr_m0_ready_count", 0, nrdy[0][0], 0);
    check("wr_rdata_kept", 0, rd1[0], 32'hDEADBEEF);
    rw1 = 1;
    repeat (4) tick();

    // simultaneous strobes after reset, each held until served
    do_reset();
    clear_obs();
    a0 = 32'h300; a1 = 32'h400; rw0 = 1; rw1 = 1; s0 = 1; s1 = 1;
    observe(30, 1'b0);
    check("tie_count", 0, log_own.size(), 2);
    if (log_own.size() >= 2) begin
      check("tie_first", 0, log_own[0], RR ? 0 : 1);
      check("tie_second", 0, log_own[1], RR ? 1 : 0);
      check("tie_first_cycle", 0, log_cyc[0], 5);
      check("tie_gap", 0, log_cyc[1] - log_cyc[0], WC0 + 2);
    end
    repeat (4) tick();

    // both held continuously for four transactions
    do_reset();
    clear_obs();
    s0 = 1; s1 = 1;
    observe(26, 1'b1);
    s0 = 0; s1 = 0;
    exp_seq = RR ? '{0, 1, 0, 1} : '{1, 1, 1, 1};
    check("stream_count", 0, log_own.size(), 4);
    for (int i = 0; i < 4 && i < log_own.size(); i++)
      check("stream_owner", i, log_own[i], exp_seq[i]);
    repeat (6) tick();

    // reset in the middle of an m0 read
    a0 = 32'h500; rw0 = 1; s0 = 1;
    tick();
    tick();
    check("pre_abort_strobe", 0, ms[0], 1);
    rst = 1'b0;
    #1;
    check("abort_strobe", 0, ms[0], 0);
    check("abort_strobe", 1, ms[1], 0);
    check("abort_ready", 0, rdy0[0], 0);
    s0 = 0;
    tick();
    rst = 1'b1;
    clear_obs();
    observe(10, 1'b0);
    check("abort_no_ready", 0, nrdy[0][0], 0);
    check("abort_idle", 0, scount[0], 0);

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      bit seen0, seen1;
      @(negedge clk);
      seen0 = rdy0[0];
      seen1 = rdy1[0];
      tick();
      mrd = $urandom;
      if (s0 ? seen0 : ($urandom_range(0, 3) == 0)) begin
        s0 = s0 ? 1'($urandom_range(0, 1)) : 1'b1;
        rw0 = 1'($urandom_range(0, 1)); a0 = $urandom; wd0 = $urandom;
      end
      if (s1 ? seen1 : ($urandom_range(0, 3) == 0)) begin
        s1 = s1 ? 1'($urandom_range(0, 1)) : 1'b1;
        rw1 = 1'($urandom_range(0, 1)); a1 = $urandom; wd1 = $urandom;
      end
    end
    s0 = 0; s1 = 0;
    repeat (10) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
